// File: rtl/axi_line_master.sv
// AXI4 burst master moving one cache line per request.
// Fills are INCR read bursts, writebacks INCR write bursts.
module axi_line_master #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_ID         = 0,
  parameter int LINE_BEATS     = 4
) (
  input  logic                                 M_AXI_ACLK,
  input  logic                                 M_AXI_ARESETN,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic                                 req_write,
  input  logic [AXI_ADDR_WIDTH-1:0]            req_addr,
  input  logic [LINE_BEATS*AXI_DATA_WIDTH-1:0] req_wdata,
  output logic                                 resp_valid,
  input  logic                                 resp_ready,
  output logic                                 resp_write,
  output logic                                 resp_error,
  output logic [LINE_BEATS*AXI_DATA_WIDTH-1:0] resp_rdata,
  output logic [AXI_ADDR_WIDTH-1:0]            M_AXI_AWADDR,
  output logic                                 M_AXI_AWVALID,
  output logic [AXI_ID_WIDTH-1:0]              M_AXI_AWID,
  output logic [1:0]                           M_AXI_AWBURST,
  output logic [2:0]                           M_AXI_AWSIZE,
  output logic [7:0]                           M_AXI_AWLEN,
  input  logic                                 M_AXI_AWREADY,
  output logic [AXI_DATA_WIDTH-1:0]            M_AXI_WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0]          M_AXI_WSTRB,
  output logic                                 M_AXI_WVALID,
  output logic                                 M_AXI_WLAST,
  input  logic                                 M_AXI_WREADY,
  input  logic [1:0]                           M_AXI_BRESP,
  input  logic                                 M_AXI_BVALID,
  input  logic [AXI_ID_WIDTH-1:0]              M_AXI_BID,
  output logic                                 M_AXI_BREADY,
  output logic [AXI_ADDR_WIDTH-1:0]            M_AXI_ARADDR,
  output logic                                 M_AXI_ARVALID,
  output logic [AXI_ID_WIDTH-1:0]              M_AXI_ARID,
  output logic [1:0]                           M_AXI_ARBURST,
  output logic [2:0]                           M_AXI_ARSIZE,
  output logic [7:0]                           M_AXI_ARLEN,
  input  logic                                 M_AXI_ARREADY,
  input  logic [AXI_DATA_WIDTH-1:0]            M_AXI_RDATA,
  input  logic [1:0]                           M_AXI_RRESP,
  input  logic                                 M_AXI_RVALID,
  input  logic [AXI_ID_WIDTH-1:0]              M_AXI_RID,
  input  logic                                 M_AXI_RLAST,
  output logic                                 M_AXI_RREADY
);

  localparam int DW = AXI_DATA_WIDTH;
  localparam int LW = LINE_BEATS * DW;
  localparam int LBYTES = LW / 8;
  localparam int CW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(LINE_BEATS - 1);
  localparam logic [AXI_ADDR_WIDTH-1:0] AMASK =
    ~(AXI_ADDR_WIDTH'(LBYTES - 1));
  localparam logic [AXI_ID_WIDTH-1:0] ID = AXI_ID_WIDTH'(AXI_ID);

  typedef enum logic [2:0] {
    IDLE, WR_BURST, WR_RESP, RD_ADDR, RD_DATA, RESP
  } state_e;

  state_e                    state_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [LW-1:0]             wline_q;
  logic [LW-1:0]             rline_q;
  logic [CW-1:0]             cnt_q;
  logic                      wr_q;
  logic                      err_q;
  logic                      awvalid_q;
  logic                      wvalid_q;
  logic                      bready_q;
  logic                      arvalid_q;
  logic                      rready_q;
  logic                      rsp_q;
  logic [DW-1:0]             wbeat;
  logic                      last;
  logic                      aw_fin;
  logic                      w_fin;
  logic                      b_bad;
  logic                      r_bad;

  assign last   = (cnt_q == LAST);
  assign aw_fin = !awvalid_q || M_AXI_AWREADY;
  assign w_fin  = !wvalid_q || (M_AXI_WREADY && last);
  assign b_bad  = (M_AXI_BRESP >= 2'b10) || (M_AXI_BID != ID);
  assign r_bad  = (M_AXI_RRESP >= 2'b10) || (M_AXI_RID != ID) ||
                  (M_AXI_RLAST != last);

  // Select the write beat addressed by the beat counter.
  always_comb begin
    wbeat = '0;
    for (int i = 0; i < LINE_BEATS; i++) begin
      if (cnt_q == CW'(i)) wbeat = wline_q[i*DW +: DW];
    end
  end

  // Transaction FSM; all handshake outputs are registered here.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wline_q   <= '0;
      rline_q   <= '0;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rsp_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr & AMASK;
            wr_q    <= req_write;
            wline_q <= req_wdata;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            if (req_write) begin
              state_q   <= WR_BURST;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= RD_ADDR;
              arvalid_q <= 1'b1;
            end
          end
        end
        WR_BURST: begin
          if (awvalid_q && M_AXI_AWREADY) awvalid_q <= 1'b0;
          if (wvalid_q && M_AXI_WREADY) begin
            if (last) wvalid_q <= 1'b0;
            else cnt_q <= cnt_q + 1'b1;
          end
          if (aw_fin && w_fin) begin
            state_q  <= WR_RESP;
            bready_q <= 1'b1;
          end
        end
        WR_RESP: begin
          if (M_AXI_BVALID) begin
            err_q    <= err_q | b_bad;
            bready_q <= 1'b0;
            rsp_q    <= 1'b1;
            state_q  <= RESP;
          end
        end
        RD_ADDR: begin
          if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (M_AXI_RVALID) begin
            for (int i = 0; i < LINE_BEATS; i++) begin
              if (cnt_q == CW'(i)) rline_q[i*DW +: DW] <= M_AXI_RDATA;
            end
            err_q <= err_q | r_bad;
            if (last) begin
              rready_q <= 1'b0;
              rsp_q    <= 1'b1;
              state_q  <= RESP;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        RESP: begin
          if (resp_ready) begin
            rsp_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready     = (state_q == IDLE) && M_AXI_ARESETN;
  assign resp_valid    = rsp_q;
  assign resp_write    = wr_q;
  assign resp_error    = err_q;
  assign resp_rdata    = rline_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_AWID    = ID;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWSIZE  = 3'($clog2(DW / 8));
  assign M_AXI_AWLEN   = 8'(LINE_BEATS - 1);
  assign M_AXI_WDATA   = wbeat;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_WLAST   = last;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARID    = ID;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARSIZE  = 3'($clog2(DW / 8));
  assign M_AXI_ARLEN   = 8'(LINE_BEATS - 1);
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_line_master.sv
// Scoreboard bench for axi_line_master.
// Directed line fills and writebacks against a small AXI slave.
`timescale 1ns/1ps
module tb_axi_line_master;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam int LB = 4;
  localparam int LW = LB * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_wdata;
  logic          resp_valid, resp_ready, resp_write, resp_error;
  logic [LW-1:0] resp_rdata;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, arvalid, arready;
  logic [IW-1:0] awid, arid, bid, rid;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic [2:0]    awsize, arsize;
  logic [7:0]    awlen, arlen;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic          wvalid, wlast, wready;
  logic          bvalid, bready;
  logic          rvalid, rlast, rready;

  axi_line_master #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
    .AXI_ID_WIDTH(IW), .AXI_ID(0), .LINE_BEATS(LB)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_write(resp_write),
    .resp_error(resp_error), .resp_rdata(resp_rdata),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWID(awid), .M_AXI_AWBURST(awburst),
    .M_AXI_AWSIZE(awsize), .M_AXI_AWLEN(awlen),
    .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata),
    .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
    .M_AXI_WLAST(wlast), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid),
    .M_AXI_BID(bid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid),
    .M_AXI_ARID(arid), .M_AXI_ARBURST(arburst),
    .M_AXI_ARSIZE(arsize), .M_AXI_ARLEN(arlen),
    .M_AXI_ARREADY(arready), .M_AXI_RDATA(rdata),
    .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RID(rid), .M_AXI_RLAST(rlast),
    .M_AXI_RREADY(rready)
  );

  typedef struct packed {
    logic          wr;
    logic          err;
    logic [LW-1:0] rd;
  } rs_t;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] exp_aw[$];
  logic [AW-1:0] exp_ar[$];
  logic [DW:0]   exp_w[$];
  rs_t           exp_rs[$];

  bit busy = 0;
  bit resp_seen = 0;
  int n_acc = 0;
  int n_w = 0;
  int n_b = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int exp_lat = -1;
  int cur_lat = -1;

  int          aw_stall = 0;
  int          resp_stall = 0;
  bit          w_rand = 0;
  bit          r_rand = 0;
  logic [1:0]  b_resp_cfg = 2'b00;
  logic [IW-1:0] b_id_cfg = '0;
  logic [IW-1:0] r_id_cfg = '0;
  logic [DW-1:0] r_data[LB];
  logic [1:0]    r_resp[LB];
  logic          r_last[LB];

  task automatic chk(input string nm, input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", nm);
  endtask

  task automatic set_r(input logic [DW-1:0] base, input int eb,
                       input int lb);
    for (int i = 0; i < LB; i++) begin
      r_data[i] = base + DW'(i);
      r_resp[i] = (i == eb) ? 2'b10 : 2'b00;
      r_last[i] = (i == lb);
    end
  endtask

  function automatic logic [LW-1:0] line4(input logic [DW-1:0] b);
    return {b + 64'd3, b + 64'd2, b + 64'd1, b};
  endfunction

  task automatic do_req(input bit wr, input logic [AW-1:0] addr,
                        input logic [LW-1:0] data, input bit err,
                        input logic [LW-1:0] rexp,
                        input logic [AW-1:0] aexp);
    int start;
    bit ok;
    rs_t e;
    if (wr) begin
      exp_aw.push_back(aexp);
      for (int i = 0; i < LB; i++)
        exp_w.push_back({i == LB - 1, data[i*DW +: DW]});
    end else begin
      exp_ar.push_back(aexp);
    end
    e.wr = wr;
    e.err = err;
    e.rd = rexp;
    exp_rs.push_back(e);
    start = n_acc;
    req_write = wr;
    req_addr = addr;
    req_wdata = data;
    req_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk); #1;
      if (n_acc != start) ok = 1;
    end
    req_valid = 1'b0;
    if (!ok) fail_now("req_accept_timeout");
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk); #1;
      if (!busy && exp_rs.size() == 0) ok = 1;
    end
    if (!ok) fail_now("idle_timeout");
  endtask

  // Scoreboard monitor: compares whatever the DUT presents.
  initial begin : monitor
    rs_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        chk("req_ready", LW'(req_ready), LW'(!busy));
        if (bvalid && bready) n_b++;
        if (awvalid) begin
          if (exp_aw.size() == 0) begin
            chk("aw_extra", LW'(awvalid), LW'(0));
          end else begin
            chk("aw", LW'({awaddr, awlen, awsize, awburst, awid}),
                LW'({exp_aw[0], 8'd3, 3'd3, 2'b01, 4'd0}));
            if (awready) void'(exp_aw.pop_front());
          end
        end
        if (wvalid) begin
          if (exp_w.size() == 0) begin
            chk("w_extra", LW'(wvalid), LW'(0));
          end else begin
            chk("w", LW'({wlast, wstrb, wdata}),
                LW'({exp_w[0][DW], 8'hFF, exp_w[0][DW-1:0]}));
            if (wready) begin
              void'(exp_w.pop_front());
              n_w++;
            end
          end
        end
        if (arvalid) begin
          if (exp_ar.size() == 0) begin
            chk("ar_extra", LW'(arvalid), LW'(0));
          end else begin
            chk("ar", LW'({araddr, arlen, arsize, arburst, arid}),
                LW'({exp_ar[0], 8'd3, 3'd3, 2'b01, 4'd0}));
            if (arready) void'(exp_ar.pop_front());
          end
        end
        if (resp_valid) begin
          if (!resp_seen) begin
            resp_seen = 1;
            if (cur_lat >= 0)
              chk("latency", LW'(cyc - acc_cyc), LW'(cur_lat));
          end
          if (exp_rs.size() == 0) begin
            chk("resp_extra", LW'(resp_valid), LW'(0));
          end else begin
            e = exp_rs[0];
            chk("resp", LW'({resp_write, resp_error}),
                LW'({e.wr, e.err}));
            if (!e.wr) chk("rdata", resp_rdata, e.rd);
            if (resp_ready) begin
              void'(exp_rs.pop_front());
              busy = 0;
            end
          end
        end
        if (req_valid && req_ready) begin
          busy = 1;
          n_acc++;
          acc_cyc = cyc;
          cur_lat = exp_lat;
          resp_seen = 0;
        end
      end
    end
  end

  // AXI slave and completion sink.
  initial begin : slave
    bit aw_hs, w_hs, wl, b_hs, ar_hs, r_hs;
    bit aw_got, w_got, r_act;
    int r_idx;
    awready = 1; wready = 1; arready = 1; resp_ready = 1;
    bvalid = 0; bresp = 0; bid = 0;
    rvalid = 0; rdata = 0; rresp = 0; rid = 0; rlast = 0;
    aw_got = 0; w_got = 0; r_act = 0; r_idx = 0;
    forever begin
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs = wvalid && wready;
      wl = wlast;
      b_hs = bvalid && bready;
      ar_hs = arvalid && arready;
      r_hs = rvalid && rready;
      @(posedge clk); #1;
      if (!rst_n) begin
        bvalid = 0; rvalid = 0; rlast = 0;
        awready = 1; wready = 1; arready = 1; resp_ready = 1;
        aw_got = 0; w_got = 0; r_act = 0; r_idx = 0;
      end else begin
        if (aw_hs) aw_got = 1;
        if (w_hs && wl) w_got = 1;
        if (b_hs) begin
          bvalid = 0;
        end else if (aw_got && w_got && !bvalid) begin
          bvalid = 1;
          bresp = b_resp_cfg;
          bid = b_id_cfg;
          aw_got = 0;
          w_got = 0;
        end
        if (awvalid && aw_stall > 0) aw_stall--;
        awready = (aw_stall == 0);
        wready = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        arready = r_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (ar_hs) begin
          r_act = 1;
          r_idx = 0;
        end
        if (r_hs) begin
          r_idx++;
          if (r_idx == LB) r_act = 0;
        end
        if (!(rvalid && !r_hs)) begin
          if (r_act && (!r_rand || $urandom_range(0, 1) == 1)) begin
            rvalid = 1;
            rdata = r_data[r_idx];
            rresp = r_resp[r_idx];
            rlast = r_last[r_idx];
            rid = r_id_cfg;
          end else begin
            rvalid = 0;
          end
        end
        if (resp_valid && resp_stall > 0) resp_stall--;
        resp_ready = (resp_stall == 0);
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int nb0;
    int nw0;
    bit ok;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    set_r(64'h0, -1, 3);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valids",
        LW'({awvalid, wvalid, arvalid, bready, rready,
             resp_valid, req_ready}), LW'(0));
    chk("rst_err", LW'(resp_error), LW'(0));
    chk("rst_rdata", resp_rdata, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    exp_lat = 6;
    do_req(1, 32'h1037,
           {64'h1111_0000_0000_0003, 64'h1111_0000_0000_0002,
            64'h1111_0000_0000_0001, 64'h1111_0000_0000_0000},
           0, '0, 32'h1020);
    exp_lat = -1;
    wait_idle();

    set_r(64'hA0, -1, 3);
    exp_lat = 6;
    do_req(0, 32'h2045, '0, 0,
           {64'hA3, 64'hA2, 64'hA1, 64'hA0}, 32'h2040);
    exp_lat = -1;
    wait_idle();

    aw_stall = 5;
    nb0 = n_b;
    do_req(1, 32'h3008, line4(64'h3300), 0, '0, 32'h3000);
    wait_idle();
    chk("b_count", LW'(n_b - nb0), LW'(1));

    set_r(64'hB0, 1, 3);
    do_req(0, 32'h401F, '0, 1, line4(64'hB0), 32'h4000);
    wait_idle();
    set_r(64'hC0, -1, 2);
    do_req(0, 32'h4020, '0, 1, line4(64'hC0), 32'h4020);
    wait_idle();
    b_resp_cfg = 2'b11;
    do_req(1, 32'h5000, line4(64'h5500), 1, '0, 32'h5000);
    wait_idle();
    b_resp_cfg = 2'b00;
    b_id_cfg = 4'd5;
    do_req(1, 32'h5020, line4(64'h5600), 1, '0, 32'h5020);
    wait_idle();
    b_id_cfg = 4'd0;
    set_r(64'hD0, -1, 3);
    do_req(0, 32'h5040, '0, 0, line4(64'hD0), 32'h5040);
    wait_idle();

    w_rand = 1;
    r_rand = 1;
    set_r(64'hE0, -1, 3);
    do_req(1, 32'h7010, line4(64'h7700), 0, '0, 32'h7000);
    resp_stall = 10;
    do_req(0, 32'h7033, '0, 0, line4(64'hE0), 32'h7020);
    do_req(1, 32'h7044, line4(64'h7800), 0, '0, 32'h7040);
    wait_idle();
    w_rand = 0;
    r_rand = 0;

    nw0 = n_w;
    do_req(1, 32'h6000, line4(64'h6600), 0, '0, 32'h6000);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (n_w - nw0 >= 2) ok = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!ok) fail_now("beat2_timeout");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst",
        LW'({awvalid, wvalid, arvalid, bready, rready,
             resp_valid, req_ready}), LW'(0));
    exp_aw.delete();
    exp_w.delete();
    exp_rs.delete();
    busy = 0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(1, 32'h6040, line4(64'h6900), 0, '0, 32'h6040);
    wait_idle();

    chk("queues_empty",
        LW'(exp_aw.size() + exp_w.size() + exp_ar.size()), LW'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_line_master.md
Name: axi_line_master

Overview:
- Parametrised AXI4 burst master that moves one whole cache line per request: line fills are read bursts and writebacks are write bursts.
- Successor to the single-beat driver. Adds configurable line length, a req/resp handshake, write-data streaming concurrent with AW, RLAST checking and error reporting.
- Sits between the cache controller (request side) and the memory interconnect (M_AXI side).

Parameters:
- AXI_ADDR_WIDTH, 32, address width.
- AXI_DATA_WIDTH, 64, data width in bits; one of 32/64/128.
- AXI_ID_WIDTH, 4, ID width.
- AXI_ID, 0, constant ID driven on AWID/ARID and expected on BID/RID.
- LINE_BEATS, 4, beats per line; power of 2, range 1..16.

Ports:
- M_AXI_ACLK  in  1  clock
- M_AXI_ARESETN  in  1  reset; asynchronous, active-low
- req_valid  in  1  request valid
- req_ready  out  1  high only in IDLE
- req_write  in  1  1 = writeback, 0 = fill
- req_addr  in  AXI_ADDR_WIDTH  line address; low log2(LINE_BEATS*AXI_DATA_WIDTH/8) bits ignored
- req_wdata  in  LINE_BEATS*AXI_DATA_WIDTH  line data; beat 0 in the LSBs
- resp_valid  out  1  completion valid
- resp_ready  in  1  completion accept
- resp_write  out  1  echo of req_write
- resp_error  out  1  any SLVERR/DECERR, ID mismatch, or RLAST misplacement
- resp_rdata  out  LINE_BEATS*AXI_DATA_WIDTH  fill data; beat 0 in the LSBs
- M_AXI_AW*: AWADDR, AWVALID, AWID, AWBURST, AWSIZE, AWLEN (out), AWREADY (in); standard AXI4 widths
- M_AXI_W*: WDATA, WSTRB, WVALID, WLAST (out), WREADY (in)
- M_AXI_B*: BRESP, BVALID, BID (in), BREADY (out)
- M_AXI_AR*: ARADDR, ARVALID, ARID, ARBURST, ARSIZE, ARLEN (out), ARREADY (in)
- M_AXI_R*: RDATA, RRESP, RVALID, RID, RLAST (in), RREADY (out)

Behaviour:
- Reset values: all VALIDs 0, BREADY 0, RREADY 0, req_ready 0 during reset, resp_valid 0, resp_error 0, resp_rdata 0; state IDLE.
- Constant fields: AxBURST=INCR (2'b01), AxSIZE=log2(AXI_DATA_WIDTH/8), AxLEN=LINE_BEATS-1, WSTRB all ones.
- Address alignment: AxADDR is the latched req_addr with line-offset bits forced to 0.
- Request capture: a request is accepted when req_valid and req_ready are both high. Address, write flag and wdata are latched in the same edge. req_ready is 0 in every state except IDLE.
- States: IDLE, WR_BURST, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE: on accept, go to WR_BURST (write) or RD_ADDR (read). AWVALID/ARVALID assert the cycle after accept.
- WR_BURST:
  - AWVALID and WVALID assert together; W does not wait for the AW handshake.
  - Each channel holds its VALID and payload stable until its own handshake; AWVALID drops after the AW handshake.
  - Beat counter advances on each WVALID&WREADY. WDATA = latched beat[count]. WLAST=1 only on beat LINE_BEATS-1.
  - Leave for WR_RESP when both the AW handshake and the last W handshake are done; they may complete in either order or the same cycle.
- WR_RESP: BREADY=1. On BVALID, record the error if BRESP[1]=1 or BID!=AXI_ID, then go to RESP.
- RD_ADDR: ARVALID=1 until ARREADY, then go to RD_DATA.
- RD_DATA:
  - RREADY=1. Each RVALID stores RDATA into beat[count] and increments count.
  - Error if RRESP[1]=1, RID!=AXI_ID, RLAST=1 before the last beat, or RLAST=0 on the last beat.
  - Go to RESP after beat LINE_BEATS-1.
- RESP:
  - resp_valid=1, with resp_rdata, resp_error and resp_write held stable until resp_ready.
  - Return to IDLE on handshake. Error and beat counter clear on the next accept.
  - resp_rdata is undefined for writes; it keeps its previous fill value.
- Minimum latency with zero-wait slave:
  - Write: accept to resp_valid = LINE_BEATS + 2 cycles.
  - Read: LINE_BEATS + 2 cycles after accept, plus slave latency.
- LINE_BEATS=1: AxLEN=0 and WLAST=1 on the only beat.
- Back-to-back: a new request is accepted in the first IDLE cycle after the resp handshake. Only one transaction is outstanding at any time.
- Reset mid-burst: return to IDLE immediately and drop all VALIDs. No recovery of the interrupted transaction; the slave is reset with the same signal.
- Error does not abort a burst; all beats are still transferred or drained.

Test Plan:
- Write, LINE_BEATS=4, req_addr=0x1037, AWREADY/WREADY/BVALID always 1, BRESP=OKAY -> AWADDR=0x1020, AWLEN=3, AWSIZE=3, four WDATA beats in order, WLAST on beat 3 only, resp_valid at cycle 6, resp_error=0.
- Read fill with RDATA beats 0xA0..0xA3 and RLAST on beat 3 -> resp_rdata = {A3,A2,A1,A0}, resp_error=0.
- Write with AWREADY delayed 5 cycles while all W beats complete first -> AWVALID/AWADDR stable throughout, single B accepted, resp issued once.
- Read with RRESP=SLVERR on beat 1, or RLAST early on beat 2 -> all beats still consumed, resp_error=1.
- Random VALID/READY backpressure on W and R, plus resp_ready held low for 10 cycles -> payloads stable while stalled, req_ready=0 until the resp handshake.
- Deassert ARESETN during WR_BURST beat 2 -> all VALIDs 0 asynchronously, next request starts a fresh burst from beat 0.
